// File: rtl/imem_dmem_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// Data access (older instruction) wins. Completed results are held until the owning stage advances.
module imem_dmem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_adv,
  output logic [31:0]   if_rdata,
  output logic          stall_if,
  input  logic [1:0]    MemReadWriteM,
  input  logic [1:0]    data_typeM,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic          mem_adv,
  output logic [31:0]   mem_rdata,
  output logic          stall_mem,
  output logic          misalign,
  output logic          bus_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUSY_MEM = 2'b01,
    BUSY_IF  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     mem_rdata_q, mem_rdata_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;
  logic            mem_done_q, mem_done_d;
  logic            if_done_q, if_done_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic            mem_pend_s;
  logic            if_pend_s;
  logic            mem_legal_s;

  function automatic logic [3:0] be_gen(input logic [1:0] dtype, input logic [1:0] a);
    logic [3:0] be;
    case (dtype)
      2'b00:   be = 4'b1111;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b0001 << a;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_gen(input logic [1:0] dtype, input logic [31:0] wd);
    logic [31:0] r;
    case (dtype)
      2'b01:   r = {2{wd[15:0]}};
      2'b10:   r = {4{wd[7:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic legal_gen(input logic [1:0] rw, input logic [1:0] dtype,
                                     input logic [1:0] a);
    logic ok;
    case (dtype)
      2'b00:   ok = (a == 2'b00);
      2'b01:   ok = ~a[0];
      2'b10:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok & (rw != 2'b11);
  endfunction

  assign mem_pend_s  = (MemReadWriteM != 2'b00) & ~mem_done_q;
  assign if_pend_s   = if_req & ~if_done_q;
  assign mem_legal_s = legal_gen(MemReadWriteM, data_typeM, mem_addr[1:0]);

  assign stall_mem = mem_pend_s;
  assign stall_if  = if_pend_s;

  // Next-state: issue in IDLE (mem first), complete or time out in BUSY.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    misalign_d  = 1'b0;
    bus_err_d   = bus_err_q;
    mem_done_d  = mem_done_q & ~mem_adv;
    if_done_d   = if_done_q & ~if_adv;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = {CW{1'b0}};
        if (mem_pend_s) begin
          if (mem_legal_s) begin
            state_d     = BUSY_MEM;
            bus_req_d   = 1'b1;
            bus_we_d    = (MemReadWriteM == 2'b01);
            bus_addr_d  = mem_addr & WORD_MASK;
            bus_be_d    = be_gen(data_typeM, mem_addr[1:0]);
            bus_wdata_d = wdata_gen(data_typeM, mem_wdata);
          end else begin
            misalign_d  = 1'b1;
            mem_done_d  = 1'b1;
            mem_rdata_d = 32'h0000_0000;
          end
        end else if (if_pend_s) begin
          state_d     = BUSY_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr & WORD_MASK;
          bus_be_d    = 4'b1111;
          bus_wdata_d = 32'h0000_0000;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_MEM, BUSY_IF: begin
        if (bus_ack || (tmo_cnt_q == TMO_LAST)) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          tmo_cnt_d = {CW{1'b0}};
          bus_err_d = bus_err_q | ~bus_ack;
          if (state_q == BUSY_MEM) begin
            mem_done_d = 1'b1;
            if (!bus_ack) begin
              mem_rdata_d = 32'h0000_0000;
            end else if (!bus_we_q) begin
              mem_rdata_d = bus_rdata;
            end else begin
              mem_rdata_d = mem_rdata_q;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = bus_ack ? bus_rdata : 32'h0000_0000;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= {AW{1'b0}};
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      if_rdata_q  <= 32'h0000_0000;
      mem_rdata_q <= 32'h0000_0000;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
      tmo_cnt_q   <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      mem_done_q  <= mem_done_d;
      if_done_q   <= if_done_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: a transaction-level reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_imem_dmem_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_adv, mem_adv, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [1:0]  MemReadWriteM, data_typeM;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        stall_if, stall_mem, misalign, bus_err, bus_req, bus_we;

  int errors = 0;
  int checks = 0;
  logic chk_on = 1'b0;
  int resp_delay = 0;
  int stray_req = 0;
  int stray_seen = 0;
  int req_cycles = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.TIMEOUT(TMO), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_adv(if_adv), .if_rdata(if_rdata), .stall_if(stall_if),
    .MemReadWriteM(MemReadWriteM), .data_typeM(data_typeM), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_adv(mem_adv), .mem_rdata(mem_rdata), .stall_mem(stall_mem),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Reference rules written as plain arithmetic on the address and access size
  function automatic logic legal_f(input logic [1:0] rw, input logic [1:0] dt, input logic [31:0] a);
    if (rw == 2'd3 || dt == 2'd3) return 1'b0;
    if (dt == 2'd0) return (a % 32'd4) == 32'd0;
    if (dt == 2'd1) return (a % 32'd2) == 32'd0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] dt, input logic [31:0] a);
    int sh;
    sh = int'(a % 32'd4);
    if (dt == 2'd0) return 4'hF;
    if (dt == 2'd1) return 4'(32'd3 << sh);
    return 4'(32'd1 << sh);
  endfunction

  function automatic logic [31:0] wd_f(input logic [1:0] dt, input logic [31:0] wd);
    if (dt == 2'd1) return {16'h0, wd[15:0]} * 32'h0001_0001;
    if (dt == 2'd2) return {24'h0, wd[7:0]} * 32'h0101_0101;
    return wd;
  endfunction

  logic        e_busy, e_for_mem, e_req, e_we, e_mis, e_err, e_mdone, e_idone;
  logic [31:0] e_addr, e_wdata, e_ird, e_mrd;
  logic [3:0]  e_be;
  int          e_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_busy <= 1'b0; e_for_mem <= 1'b0; e_req <= 1'b0; e_we <= 1'b0; e_mis <= 1'b0;
      e_err <= 1'b0; e_mdone <= 1'b0; e_idone <= 1'b0; e_addr <= 32'h0; e_wdata <= 32'h0;
      e_ird <= 32'h0; e_mrd <= 32'h0; e_be <= 4'h0; e_cnt <= 0;
    end else begin
      e_mis <= 1'b0;
      if (e_mdone && mem_adv) e_mdone <= 1'b0;
      if (e_idone && if_adv) e_idone <= 1'b0;
      if (e_busy) begin
        if (bus_ack || e_cnt + 1 == TMO) begin
          e_busy <= 1'b0; e_req <= 1'b0; e_cnt <= 0;
          if (!bus_ack) e_err <= 1'b1;
          if (e_for_mem) begin
            e_mdone <= 1'b1;
            if (!bus_ack) e_mrd <= 32'h0;
            else if (!e_we) e_mrd <= bus_rdata;
          end else begin
            e_idone <= 1'b1;
            e_ird <= bus_ack ? bus_rdata : 32'h0;
          end
        end else begin
          e_cnt <= e_cnt + 1;
        end
      end else if (MemReadWriteM != 2'd0 && !e_mdone) begin
        if (!legal_f(MemReadWriteM, data_typeM, mem_addr)) begin
          e_mis <= 1'b1; e_mdone <= 1'b1; e_mrd <= 32'h0;
        end else begin
          e_busy <= 1'b1; e_for_mem <= 1'b1; e_req <= 1'b1; e_cnt <= 0;
          e_we <= (MemReadWriteM == 2'd1);
          e_addr <= mem_addr - (mem_addr % 32'd4);
          e_be <= be_f(data_typeM, mem_addr);
          e_wdata <= wd_f(data_typeM, mem_wdata);
        end
      end else if (if_req && !e_idone) begin
        e_busy <= 1'b1; e_for_mem <= 1'b0; e_req <= 1'b1; e_cnt <= 0; e_we <= 1'b0;
        e_addr <= if_addr - (if_addr % 32'd4); e_be <= 4'hF; e_wdata <= 32'h0;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("bus_req", 32'(bus_req), 32'(e_req));
      if (e_req) begin
        chk("bus_we", 32'(bus_we), 32'(e_we));
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_be", 32'(bus_be), 32'(e_be));
        chk("bus_wdata", bus_wdata, e_wdata);
      end
      chk("if_rdata", if_rdata, e_ird);
      chk("mem_rdata", mem_rdata, e_mrd);
      chk("misalign", 32'(misalign), 32'(e_mis));
      chk("bus_err", 32'(bus_err), 32'(e_err));
      chk("stall_if", 32'(stall_if), 32'(if_req && !e_idone));
      chk("stall_mem", 32'(stall_mem), 32'(MemReadWriteM != 2'd0 && !e_mdone));
    end
  end

  // Bus responder: acks resp_delay cycles after bus_req rises; negative delay never acks
  always begin
    @(posedge clk); #1;
    if (stray_req != stray_seen) begin
      bus_ack = 1'b1;
      stray_seen = stray_req;
    end else if (bus_req && !bus_ack && resp_delay >= 0 && req_cycles >= resp_delay) begin
      bus_ack = 1'b1;
      bus_rdata = rd_of(bus_addr);
    end else begin
      bus_ack = 1'b0;
      if (bus_req) req_cycles = req_cycles + 1;
      else req_cycles = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_req(input logic lvl, input string name);
    int k;
    k = 0;
    while (bus_req !== lvl && k < 30) begin step(1); k++; end
    chk(name, 32'(bus_req), 32'(lvl));
  endtask

  task automatic wait_stall_if_low(input string name);
    int k;
    k = 0;
    while (stall_if !== 1'b0 && k < 30) begin step(1); k++; end
    chk(name, 32'(stall_if), 32'h0);
  endtask

  task automatic wait_stall_mem_low(input string name);
    int k;
    k = 0;
    while (stall_mem !== 1'b0 && k < 30) begin step(1); k++; end
    chk(name, 32'(stall_mem), 32'h0);
  endtask

  task automatic mem_retire();
    MemReadWriteM = 2'b00; mem_adv = 1'b1; step(1); mem_adv = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b0; if_req = 1'b0; if_adv = 1'b0; mem_adv = 1'b0; bus_ack = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; bus_rdata = 32'h0;
    MemReadWriteM = 2'b00; data_typeM = 2'b00;
    #1 chk_on = 1'b1;
    step(2);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    reset = 1'b1;
    step(2);

    // Fetch only, ack two cycles after request
    resp_delay = 2; if_req = 1'b1; if_addr = 32'h100;
    wait_req(1'b1, "t1_req");
    chk("t1_addr", bus_addr, 32'h100);
    chk("t1_be", 32'(bus_be), 32'hF);
    chk("t1_we", 32'(bus_we), 32'h0);
    k = 0;
    while (stall_if !== 1'b0 && k < 30) begin step(1); k++; end
    chk("t1_lat", k, 3);
    chk("t1_rdata", if_rdata, 32'h00500093);
    if_req = 1'b0; if_adv = 1'b1; step(1); if_adv = 1'b0;

    // Simultaneous load word and fetch: load goes first
    resp_delay = 1; MemReadWriteM = 2'b10; data_typeM = 2'b00; mem_addr = 32'h2004;
    if_req = 1'b1; if_addr = 32'h104;
    wait_req(1'b1, "t2_req1");
    chk("t2_addr1", bus_addr, 32'h2004);
    wait_req(1'b0, "t2_drop");
    chk("t2_mrd", mem_rdata, 32'h2004DFFB);
    chk("t2_stall_if", 32'(stall_if), 32'h1);
    step(1);
    chk("t2_req2", 32'(bus_req), 32'h1);
    chk("t2_addr2", bus_addr, 32'h104);
    wait_stall_if_low("t2_if_done");
    chk("t2_ird", if_rdata, 32'h0104FEFB);
    step(3);
    chk("t2_no_reissue", 32'(bus_req), 32'h0);
    chk("t2_mrd_hold", mem_rdata, 32'h2004DFFB);
    MemReadWriteM = 2'b00; if_req = 1'b0; mem_adv = 1'b1; if_adv = 1'b1;
    step(1); mem_adv = 1'b0; if_adv = 1'b0;

    // Store byte and store half
    resp_delay = 0; MemReadWriteM = 2'b01; data_typeM = 2'b10; mem_addr = 32'h3003; mem_wdata = 32'hAB;
    wait_req(1'b1, "t3_req");
    chk("t3_be", 32'(bus_be), 32'h8);
    chk("t3_wdata", bus_wdata, 32'hABABABAB);
    chk("t3_we", 32'(bus_we), 32'h1);
    chk("t3_addr", bus_addr, 32'h3000);
    wait_stall_mem_low("t3_done");
    mem_retire();
    MemReadWriteM = 2'b01; data_typeM = 2'b01; mem_addr = 32'h3002; mem_wdata = 32'h1234;
    wait_req(1'b1, "t3h_req");
    chk("t3h_be", 32'(bus_be), 32'hC);
    chk("t3h_wdata", bus_wdata, 32'h12341234);
    wait_stall_mem_low("t3h_done");
    mem_retire();

    // Stray ack while idle must be ignored
    stray_req++; step(3);

    // Misaligned half load, then illegal MemReadWriteM
    MemReadWriteM = 2'b10; data_typeM = 2'b01; mem_addr = 32'h3001;
    step(1);
    chk("t4_mis", 32'(misalign), 32'h1);
    chk("t4_stall", 32'(stall_mem), 32'h0);
    chk("t4_noreq", 32'(bus_req), 32'h0);
    chk("t4_mrd", mem_rdata, 32'h0);
    step(2);
    chk("t4_pulse", 32'(misalign), 32'h0);
    mem_retire();
    MemReadWriteM = 2'b11; data_typeM = 2'b00; mem_addr = 32'h3000;
    step(1);
    chk("t4b_mis", 32'(misalign), 32'h1);
    mem_retire();

    // Timeout: no ack ever
    resp_delay = -1; MemReadWriteM = 2'b10; data_typeM = 2'b00; mem_addr = 32'h4000;
    wait_req(1'b1, "t5_req");
    k = 0;
    while (bus_req !== 1'b0 && k < 20) begin step(1); k++; end
    chk("t5_busy_cycles", k, TMO);
    chk("t5_err", 32'(bus_err), 32'h1);
    chk("t5_mrd", mem_rdata, 32'h0);
    mem_retire();
    step(2);
    chk("t5_sticky", 32'(bus_err), 32'h1);

    // Reset in the middle of a fetch
    if_req = 1'b1; if_addr = 32'h108;
    wait_req(1'b1, "t6_req");
    step(1);
    #1 reset = 1'b0;
    #1;
    chk("t6_req", 32'(bus_req), 32'h0);
    chk("t6_err", 32'(bus_err), 32'h0);
    chk("t6_ird", if_rdata, 32'h0);
    chk("t6_addr", bus_addr, 32'h0);
    chk("t6_be", 32'(bus_be), 32'h0);
    if_req = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    chk("t6_after", 32'(bus_req), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one external memory port between instruction fetch (F stage) and data access (M stage) of the 5-stage RISC-V pipeline.
- Sequences variable-latency bus transactions, generates byte enables from the M-stage control bits (MemReadWriteM, data_typeM), holds read data until the pipeline advances, and produces stall requests for the Hazard Unit.
- Data access has priority over fetch: it belongs to the older instruction.

Parameters:
- TIMEOUT, 255: max cycles waiting for bus_ack before the transaction is aborted.
- AW, 32: address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request valid (PCF valid)
- if_addr  in  AW  fetch address, word aligned
- if_adv  in  1  F stage advancing this cycle (~StallF)
- if_rdata  out  32  fetched instruction, registered
- stall_if  out  1  fetch not yet complete
- MemReadWriteM  in  2  10 = load, 01 = store, 00 = none, 11 = illegal
- data_typeM  in  2  00 = word, 01 = half, 10 = byte, 11 = illegal
- mem_addr  in  AW  ALU result
- mem_wdata  in  32  store data, right-aligned
- mem_adv  in  1  M stage advancing this cycle (~StallM)
- mem_rdata  out  32  raw loaded word, registered; extension is done downstream
- stall_mem  out  1  data access not yet complete
- misalign  out  1  one-cycle pulse on a misaligned or illegal access
- bus_err  out  1  sticky timeout flag
- bus_req  out  1  bus transaction valid, registered
- bus_we  out  1  write
- bus_addr  out  AW  word address, [1:0] = 00
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_rdata  in  32  bus read data
- bus_ack  in  1  one-cycle completion, may come 1..N cycles after req

Behaviour:
- FSM states: IDLE, BUSY_MEM, BUSY_IF.
- Reset (reset = 0, async) forces all of the following to 0: state = IDLE, bus_req, bus_we, bus_addr, bus_be, bus_wdata, if_rdata, mem_rdata, misalign, bus_err, done flags, timeout counter.
- Pending conditions:
  - mem_pend = MemReadWriteM != 00 & ~mem_done.
  - if_pend = if_req & ~if_done.
- Stall outputs: stall_mem = mem_pend; stall_if = if_pend. Both are combinational from state and flags.
- IDLE behaviour:
  - If mem_pend and the access is legal: latch address, write enable, byte enables and write data; go to BUSY_MEM; bus_req = 1 from the next cycle.
  - Else if if_pend: latch if_addr with bus_be = 1111, bus_we = 0; go to BUSY_IF.
  - When both are pending, mem wins; fetch is issued after mem completes.
- BUSY state behaviour:
  - bus_req and all bus fields hold stable until bus_ack.
  - On bus_ack: drop bus_req the next cycle. For a load or fetch, capture bus_rdata into mem_rdata or if_rdata. Set mem_done or if_done. Return to IDLE.
  - Minimum latency is 3 cycles from request to stall release when bus_ack arrives the cycle after bus_req.
- Done flags:
  - mem_done holds, and mem_rdata stays stable, until mem_adv = 1. It clears on that cycle, so the next M instruction can issue.
  - if_done behaves the same with if_adv.
  - A done flag is never cleared while its stage is stalled. This prevents reissuing a completed access while the other requester still stalls the pipeline.
- Byte enables and write data:
  - word: be = 1111.
  - half: be = 0011 << (2*addr[1]); wdata = {2{wdata[15:0]}}.
  - byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- Misalignment:
  - Misaligned cases: half with addr[0] = 1, word with addr[1:0] != 0, data_typeM = 11, or MemReadWriteM = 11.
  - Response: no bus transaction; misalign pulses for 1 cycle; mem_done set; mem_rdata = 0.
- Timeout:
  - A counter increments each BUSY cycle without bus_ack.
  - When it reaches TIMEOUT: drop bus_req, set bus_err (sticky until reset), complete the access with rdata = 0, go to IDLE.
- bus_ack while in IDLE is ignored.
- if_adv or mem_adv asserted while the corresponding access is pending has no effect. The Hazard Unit never does this.
- Reset asserted mid-transaction aborts it immediately: bus_req = 0 and no capture.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x100, bus_ack 2 cycles after bus_req with rdata 0x00500093 -> bus_addr = 0x100, be = 1111, if_rdata = 0x00500093, stall_if low the cycle after ack.
- Simultaneous requests: load word at 0x2004 together with fetch at 0x104 -> the 0x2004 transaction is issued first; 0x104 is issued in the cycle after returning to IDLE; stall_if stays high until both done flags are set.
- Store byte: MemReadWriteM = 01, data_typeM = 10, addr = 0x3003, wdata = 0xAB -> be = 1000, bus_wdata = 0xABABABAB, bus_we = 1.
- Misaligned half at 0x3001 -> misalign pulses once, no bus_req, mem_rdata = 0, stall_mem clears the next cycle.
- Held completion: load completes while if_pend persists (mem_adv = 0) -> no second mem transaction; mem_rdata stays stable until mem_adv = 1.
- Timeout: no bus_ack with TIMEOUT = 4 -> bus_req drops after 4 BUSY cycles, bus_err = 1 until reset; reset low mid-transaction -> all outputs 0 immediately.
